ysyx_22050019_ifu: RTL and testbench

YSYX_22050019_IFU -- requirements
Module: ysyx_22050019_ifu

---
 rtl/ysyx_22050019_ifu.sv | 155 +++++++++++++++
 tb/tb_ysyx_22050019_ifu.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050019_ifu.sv
// ysyx_22050019_ifu -- instruction fetch unit
//
// Fetches one 32-bit instruction at a time from an icache and hands it to
// decode. At most one request is outstanding. A redirect (branch/jump/trap)
// replaces the sequential PC; a fetch already in flight when a redirect
// arrives is completed and its data thrown away.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   redirect_valid_i/_pc_i    redirect strobe and target PC
//   ar_valid_o/ar_ready_i     fetch request handshake, ar_addr_o = full PC
//   r_valid_i/r_ready_o       return handshake, r_resp_i (0 = OKAY),
//                             r_data_i = aligned doubleword holding the PC
//   inst_valid_o/inst_ready_i handshake to decode carrying inst_o, pc_o,
//                             inst_err_o
//   fetch_cnt_o               number of instructions accepted by decode
module ysyx_22050019_ifu #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  output logic [ADDR_WIDTH-1:0] ar_addr_o,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  input  logic [1:0]            r_resp_i,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [31:0]           inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  inst_err_o,
  output logic [63:0]           fetch_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;           // address of the current fetch
  logic [ADDR_WIDTH-1:0] redir_pc_q, redir_pc_d; // pending redirect target
  logic                  flush_q, flush_d;     // in-flight fetch must be dropped
  logic [31:0]           inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                  err_q, err_d;
  logic [63:0]           cnt_q, cnt_d;

  // Handshake flags come straight from the state register.
  assign ar_valid_o   = (state_q == S_AR);
  assign r_ready_o    = (state_q == S_R);
  assign inst_valid_o = (state_q == S_OUT);
  assign ar_addr_o    = pc_q;
  assign inst_o       = inst_q;
  assign pc_o         = pc_out_q;
  assign inst_err_o   = err_q;
  assign fetch_cnt_o  = cnt_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    flush_d    = flush_q;
    inst_d     = inst_q;
    pc_out_d   = pc_out_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    case (state_q)
      // Redirects are ignored here: the first fetch always uses RESET_PC.
      S_IDLE: state_d = S_AR;

      // The request address must not move while waiting for the icache, so a
      // redirect is only remembered and the current fetch is marked stale.
      S_AR: begin
        if (redirect_valid_i) begin
          redir_pc_d = redirect_pc_i;
          flush_d    = 1'b1;
        end
        if (ar_ready_i) begin
          state_d = S_R;
        end
      end

      S_R: begin
        if (redirect_valid_i) begin
          redir_pc_d = redirect_pc_i;
          flush_d    = 1'b1;
        end
        if (r_valid_i) begin
          if (flush_q || redirect_valid_i) begin
            // Stale data: drop it and restart at the newest redirect target.
            pc_d    = redirect_valid_i ? redirect_pc_i : redir_pc_q;
            flush_d = 1'b0;
            state_d = S_AR;
          end else begin
            // PC bit 2 selects which half of the doubleword holds the word.
            inst_d   = pc_q[2] ? r_data_i[32 +: 32] : r_data_i[0 +: 32];
            pc_out_d = pc_q;
            err_d    = |r_resp_i;
            state_d  = S_OUT;
          end
        end
      end

      S_OUT: begin
        // A handshake in the same cycle as a redirect still counts as a
        // delivery, but the redirect target decides the next PC.
        if (inst_ready_i) begin
          cnt_d = cnt_q + 64'd1;
        end
        if (redirect_valid_i) begin
          pc_d    = redirect_pc_i;
          state_d = S_AR;
        end else if (inst_ready_i) begin
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = S_AR;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      redir_pc_q <= '0;
      flush_q    <= 1'b0;
      inst_q     <= '0;
      pc_out_q   <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      flush_q    <= flush_d;
      inst_q     <= inst_d;
      pc_out_q   <= pc_out_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// Testbench for ysyx_22050019_ifu: directed scenarios with literal
// expectations followed by randomized icache/decode/redirect traffic. A
// transaction-level model (next fetch PC, outstanding request, pending
// redirect, buffered instruction, delivery count) is checked every cycle.
module tb_ysyx_22050019_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        ar_valid_o;
  logic        ar_ready_i = 1'b0;
  logic [63:0] ar_addr_o;
  logic        r_valid_i = 1'b0;
  logic        r_ready_o;
  logic [1:0]  r_resp_i = 2'b00;
  logic [63:0] r_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        inst_err_o;
  logic [63:0] fetch_cnt_o;

  int checks = 0;
  int errors = 0;

  ysyx_22050019_ifu #(
    .ADDR_WIDTH(64),
    .DATA_WIDTH(64),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .ar_valid_o      (ar_valid_o),
    .ar_ready_i      (ar_ready_i),
    .ar_addr_o       (ar_addr_o),
    .r_valid_i       (r_valid_i),
    .r_ready_o       (r_ready_o),
    .r_resp_i        (r_resp_i),
    .r_data_i        (r_data_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .inst_err_o      (inst_err_o),
    .fetch_cnt_o     (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  // Memory image seen through the icache: one doubleword per aligned address.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] al;
    logic [31:0] k;
    al = {a[63:3], 3'b000};
    if (al == 64'h0000_0000_8000_0000) return 64'h00100093_00000013;
    k = al[34:3] ^ al[63:32];
    return {(k * 32'h9E37_79B1) ^ 32'h5A5A_0001, (k * 32'h85EB_CA6B) + 32'd7};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic        m_started = 1'b0;
  logic [63:0] m_next_pc = RESET_PC;  // address the next request must carry
  logic        m_out = 1'b0;          // request accepted, data not yet returned
  logic [63:0] m_req_pc = RESET_PC;   // address of the outstanding request
  logic        m_pend = 1'b0;         // redirect waiting for the in-flight fetch
  logic [63:0] m_pend_pc = '0;
  logic        m_buf = 1'b0;          // instruction waiting for decode
  logic [31:0] m_buf_inst = '0;
  logic [63:0] m_buf_pc = '0;
  logic        m_buf_err = 1'b0;
  logic [63:0] m_cnt = '0;
  logic [63:0] m_w;

  // The icache returns the doubleword of the outstanding request.
  assign r_data_i = mem_word(m_req_pc);

  // Check at the falling edge, then advance the model with the inputs that the
  // next rising edge will see.
  always @(negedge clk) begin
    if (!rst) begin
      m_started = 1'b0; m_next_pc = RESET_PC; m_out = 1'b0;
      m_pend = 1'b0; m_buf = 1'b0; m_cnt = '0;
      chk("rst_ar_valid", {63'd0, ar_valid_o}, 64'd0);
      chk("rst_r_ready", {63'd0, r_ready_o}, 64'd0);
      chk("rst_inst_valid", {63'd0, inst_valid_o}, 64'd0);
      chk("rst_inst", {32'd0, inst_o}, 64'd0);
      chk("rst_pc_o", pc_o, 64'd0);
      chk("rst_err", {63'd0, inst_err_o}, 64'd0);
      chk("rst_cnt", fetch_cnt_o, 64'd0);
    end else begin
      chk("m_ar_valid", {63'd0, ar_valid_o}, {63'd0, m_started && !m_out && !m_buf});
      chk("m_r_ready", {63'd0, r_ready_o}, {63'd0, m_out});
      chk("m_inst_valid", {63'd0, inst_valid_o}, {63'd0, m_buf});
      if (m_started && !m_out && !m_buf) chk("m_ar_addr", ar_addr_o, m_next_pc);
      if (m_buf) begin
        chk("m_inst", {32'd0, inst_o}, {32'd0, m_buf_inst});
        chk("m_pc_o", pc_o, m_buf_pc);
        chk("m_err", {63'd0, inst_err_o}, {63'd0, m_buf_err});
      end
      chk("m_cnt", fetch_cnt_o, m_cnt);

      if (!m_started) begin
        m_started = 1'b1;
      end else if (m_buf) begin
        if (inst_ready_i) m_cnt = m_cnt + 64'd1;
        if (redirect_valid_i) begin
          m_next_pc = redirect_pc_i; m_buf = 1'b0;
        end else if (inst_ready_i) begin
          m_next_pc = m_buf_pc + 64'd4; m_buf = 1'b0;
        end
      end else if (m_out) begin
        if (redirect_valid_i) begin m_pend = 1'b1; m_pend_pc = redirect_pc_i; end
        if (r_valid_i) begin
          m_out = 1'b0;
          if (m_pend) begin
            m_next_pc = m_pend_pc; m_pend = 1'b0;
          end else begin
            m_w = mem_word(m_req_pc);
            m_buf = 1'b1;
            m_buf_pc = m_req_pc;
            m_buf_inst = m_req_pc[2] ? m_w[63:32] : m_w[31:0];
            m_buf_err = (r_resp_i != 2'b00);
          end
        end
      end else begin
        if (redirect_valid_i) begin m_pend = 1'b1; m_pend_pc = redirect_pc_i; end
        if (ar_ready_i) begin m_out = 1'b1; m_req_pc = m_next_pc; end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic sig_of(input int which);
    case (which)
      0: return ar_valid_o;
      1: return r_ready_o;
      default: return inst_valid_o;
    endcase
  endfunction

  // Advance whole cycles (sampling at posedge+1) until the flag is high.
  task automatic wait_for(input int which, input string name, output int steps);
    steps = 0;
    while (!sig_of(which) && steps < 50) begin
      @(posedge clk); #1;
      steps++;
    end
    if (!sig_of(which)) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int st;
    logic [63:0] w;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Two sequential fetches from a zero-wait icache.
    ar_ready_i = 1'b1; r_valid_i = 1'b1; inst_ready_i = 1'b1;
    wait_for(0, "t1_ar0", st);
    chk("t1_addr0", ar_addr_o, 64'h8000_0000);
    wait_for(2, "t1_inst0", st);
    chk("t1_latency", st, 2);
    chk("t1_inst0", {32'd0, inst_o}, 64'h0000_0013);
    chk("t1_pc0", pc_o, 64'h8000_0000);
    wait_for(0, "t1_ar1", st);
    chk("t1_addr1", ar_addr_o, 64'h8000_0004);
    wait_for(2, "t1_inst1", st);
    chk("t1_inst1", {32'd0, inst_o}, 64'h0010_0093);

    // Decode stalls for five cycles on the second instruction.
    inst_ready_i = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t2_valid", {63'd0, inst_valid_o}, 64'd1);
      chk("t2_no_ar", {63'd0, ar_valid_o}, 64'd0);
      chk("t2_inst", {32'd0, inst_o}, 64'h0010_0093);
      chk("t2_pc", pc_o, 64'h8000_0004);
      chk("t2_cnt", fetch_cnt_o, 64'd1);
    end
    inst_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("t2_cnt_after", fetch_cnt_o, 64'd2);
    chk("t2_ar_after", {63'd0, ar_valid_o}, 64'd1);
    chk("t2_addr_after", ar_addr_o, 64'h8000_0008);

    // Redirect while the icache refuses the request.
    ar_ready_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_1000;
    @(posedge clk); #1;
    redirect_valid_i = 1'b0; redirect_pc_i = 64'h1234_5678_9ABC_DEF0;
    repeat (3) begin
      chk("t3_hold_valid", {63'd0, ar_valid_o}, 64'd1);
      chk("t3_hold_addr", ar_addr_o, 64'h8000_0008);
      @(posedge clk); #1;
    end
    ar_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("t3_r_ready", {63'd0, r_ready_o}, 64'd1);
    @(posedge clk); #1;
    chk("t3_discard_no_inst", {63'd0, inst_valid_o}, 64'd0);
    chk("t3_new_ar", {63'd0, ar_valid_o}, 64'd1);
    chk("t3_new_addr", ar_addr_o, 64'h8000_1000);
    chk("t3_cnt", fetch_cnt_o, 64'd2);
    wait_for(2, "t3_inst", st);
    chk("t3_pc", pc_o, 64'h8000_1000);
    w = mem_word(64'h8000_1000);
    chk("t3_inst_val", {32'd0, inst_o}, {32'd0, w[31:0]});
    @(posedge clk); #1;

    // Redirect in the output stage together with a decode handshake.
    inst_ready_i = 1'b0;
    wait_for(2, "t4_inst", st);
    chk("t4_pc", pc_o, 64'h8000_1004);
    chk("t4_cnt_before", fetch_cnt_o, 64'd3);
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_2000; inst_ready_i = 1'b1;
    @(posedge clk); #1;
    redirect_valid_i = 1'b0; inst_ready_i = 1'b0;
    chk("t4_cnt_after", fetch_cnt_o, 64'd4);
    chk("t4_ar", {63'd0, ar_valid_o}, 64'd1);
    chk("t4_addr", ar_addr_o, 64'h8000_2000);

    // Error response, then a clean one.
    r_resp_i = 2'b10;
    wait_for(2, "t5_err_inst", st);
    chk("t5_err", {63'd0, inst_err_o}, 64'd1);
    chk("t5_pc", pc_o, 64'h8000_2000);
    r_resp_i = 2'b00; inst_ready_i = 1'b1;
    @(posedge clk); #1;
    wait_for(2, "t5_ok_inst", st);
    chk("t5_ok", {63'd0, inst_err_o}, 64'd0);
    chk("t5_pc2", pc_o, 64'h8000_2004);

    // Asynchronous reset while waiting for return data.
    r_valid_i = 1'b0; ar_ready_i = 1'b1;
    @(posedge clk); #1;
    wait_for(1, "t6_r", st);
    #2 rst = 1'b0;
    #1;
    chk("t6_ar_valid", {63'd0, ar_valid_o}, 64'd0);
    chk("t6_r_ready", {63'd0, r_ready_o}, 64'd0);
    chk("t6_inst_valid", {63'd0, inst_valid_o}, 64'd0);
    chk("t6_inst", {32'd0, inst_o}, 64'd0);
    chk("t6_pc_o", pc_o, 64'd0);
    chk("t6_cnt", fetch_cnt_o, 64'd0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    r_valid_i = 1'b1;
    wait_for(0, "t6_ar", st);
    chk("t6_addr", ar_addr_o, RESET_PC);

    // Redirect during the first cycle after reset is ignored.
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_5000;
    @(posedge clk); #1;
    redirect_valid_i = 1'b0;
    chk("t7_ar", {63'd0, ar_valid_o}, 64'd1);
    chk("t7_addr", ar_addr_o, RESET_PC);
    wait_for(2, "t7_inst", st);
    chk("t7_pc", pc_o, RESET_PC);

    // Randomized traffic, including targets that wrap the 64-bit PC.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      ar_ready_i   = ($urandom_range(0, 3) != 0);
      r_valid_i    = ($urandom_range(0, 3) != 0);
      inst_ready_i = ($urandom_range(0, 2) != 0);
      r_resp_i     = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      redirect_valid_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0)
        redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF8;
      else if (redirect_valid_i)
        redirect_pc_i = 64'h8000_0000 + (64'($urandom_range(0, 1023)) << 2);
      else
        redirect_pc_i = {$urandom, $urandom};
    end
    redirect_valid_i = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
